// File: rtl/alu_op_sequencer_if.sv
// Control bundle between the instruction sequencer and its datapath: run/IR/finished
// inputs and the per-state strobe, select and status outputs.
interface alu_op_sequencer_if;
  logic        i_run;
  logic [31:0] i_irq;
  logic        i_finished;

  logic        o_pcout;
  logic        o_incpc;
  logic        o_marin;
  logic        o_rzin;
  logic        o_rzloout;
  logic        o_pcin;
  logic        o_read;
  logic        o_mdrin;
  logic        o_mdrout;
  logic        o_irin;
  logic        o_rfout;
  logic        o_ryin;
  logic        o_rfin;
  logic        o_rzhiout;
  logic        o_rloin;
  logic        o_rhiin;
  logic [3:0]  o_rfselect;
  logic [5:0]  o_opselect;
  logic        o_start;
  logic        o_busy;
  logic        o_err;

  modport master (
    output i_run, i_irq, i_finished,
    input  o_pcout, o_incpc, o_marin, o_rzin, o_rzloout, o_pcin, o_read, o_mdrin,
    input  o_mdrout, o_irin, o_rfout, o_ryin, o_rfin, o_rzhiout, o_rloin, o_rhiin,
    input  o_rfselect, o_opselect, o_start, o_busy, o_err
  );

  modport slave (
    input  i_run, i_irq, i_finished,
    output o_pcout, o_incpc, o_marin, o_rzin, o_rzloout, o_pcin, o_read, o_mdrin,
    output o_mdrout, o_irin, o_rfout, o_ryin, o_rfin, o_rzhiout, o_rloin, o_rhiin,
    output o_rfselect, o_opselect, o_start, o_busy, o_err
  );
endinterface

// File: rtl/alu_op_sequencer.sv
// Moore control FSM that fetches, decodes and executes one ALU instruction at a time.
// Optional feature macro ALU_TIMEOUT_EN: abort a WAIT that lasts 64 cycles and flag err.
module alu_op_sequencer (
  input  logic                  i_clk,
  input  logic                  i_clear,
  alu_op_sequencer_if.slave     bus
);

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_T0   = 4'd1,
    S_T1   = 4'd2,
    S_T2   = 4'd3,
    S_T3   = 4'd4,
    S_T4   = 4'd5,
    S_WAIT = 4'd6,
    S_T5   = 4'd7,
    S_T6   = 4'd8
  } state_t;

  function automatic logic is_legal(input logic [4:0] op);
    return (op >= 5'h03) && (op <= 5'h1A);
  endfunction

  function automatic logic is_muldiv(input logic [4:0] op);
    return (op == 5'h0E) || (op == 5'h0F);
  endfunction

  state_t      r_state;
  state_t      w_next;
  logic        r_err;
  logic        w_err_set;
  logic [4:0]  w_opcode;
  logic [3:0]  w_ra;
  logic [3:0]  w_rb;
  logic [3:0]  w_rc;

  assign w_opcode = bus.i_irq[31:27];
  assign w_ra     = bus.i_irq[26:23];
  assign w_rb     = bus.i_irq[22:19];
  assign w_rc     = bus.i_irq[18:15];

`ifdef ALU_TIMEOUT_EN
  logic [5:0]  r_wait_cnt;
  logic        w_timeout;

  assign w_timeout = (r_wait_cnt == 6'd63);

  // WAIT-cycle counter: held at zero outside WAIT so every entry starts fresh
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_wait_cnt <= 6'd0;
    end else if (r_state != S_WAIT) begin
      r_wait_cnt <= 6'd0;
    end else if (!w_timeout) begin
      r_wait_cnt <= r_wait_cnt + 6'd1;
    end else begin
      r_wait_cnt <= r_wait_cnt;
    end
  end
`endif

  // State register and sticky error flag; clear overrides everything
  always_ff @(posedge i_clk) begin
    if (i_clear) begin
      r_state <= S_IDLE;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_err_set) begin
        r_err <= 1'b1;
      end else begin
        r_err <= r_err;
      end
    end
  end

  // Next-state logic; IRq is only trusted from T3 onward
  always_comb begin
    w_next    = r_state;
    w_err_set = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.i_run && !r_err) begin
          w_next = S_T0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_T0: w_next = S_T1;
      S_T1: w_next = S_T2;
      S_T2: w_next = S_T3;
      S_T3: begin
        if (is_legal(w_opcode)) begin
          w_next = S_T4;
        end else begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
        end
      end
      S_T4: w_next = S_WAIT;
      S_WAIT: begin
        if (bus.i_finished) begin
          w_next = S_T5;
`ifdef ALU_TIMEOUT_EN
        end else if (w_timeout) begin
          w_next    = S_IDLE;
          w_err_set = 1'b1;
`endif
        end else begin
          w_next = S_WAIT;
        end
      end
      S_T5: begin
        if (is_muldiv(w_opcode)) begin
          w_next = S_T6;
        end else if (bus.i_run) begin
          w_next = S_T0;
        end else begin
          w_next = S_IDLE;
        end
      end
      S_T6: begin
        if (bus.i_run) begin
          w_next = S_T0;
        end else begin
          w_next = S_IDLE;
        end
      end
      default: w_next = S_IDLE;
    endcase
  end

  // Moore output decode: strobes depend on the state register alone
  always_comb begin
    bus.o_pcout    = 1'b0;
    bus.o_incpc    = 1'b0;
    bus.o_marin    = 1'b0;
    bus.o_rzin     = 1'b0;
    bus.o_rzloout  = 1'b0;
    bus.o_pcin     = 1'b0;
    bus.o_read     = 1'b0;
    bus.o_mdrin    = 1'b0;
    bus.o_mdrout   = 1'b0;
    bus.o_irin     = 1'b0;
    bus.o_rfout    = 1'b0;
    bus.o_ryin     = 1'b0;
    bus.o_rfin     = 1'b0;
    bus.o_rzhiout  = 1'b0;
    bus.o_rloin    = 1'b0;
    bus.o_rhiin    = 1'b0;
    bus.o_rfselect = 4'd0;
    bus.o_opselect = 6'd0;
    bus.o_start    = 1'b0;
    case (r_state)
      S_IDLE: begin
        bus.o_start = 1'b0;
      end
      S_T0: begin
        bus.o_pcout = 1'b1;
        bus.o_marin = 1'b1;
        bus.o_incpc = 1'b1;
        bus.o_rzin  = 1'b1;
      end
      S_T1: begin
        bus.o_rzloout = 1'b1;
        bus.o_pcin    = 1'b1;
        bus.o_read    = 1'b1;
        bus.o_mdrin   = 1'b1;
      end
      S_T2: begin
        bus.o_mdrout = 1'b1;
        bus.o_irin   = 1'b1;
      end
      S_T3: begin
        bus.o_rfout    = 1'b1;
        bus.o_ryin     = 1'b1;
        bus.o_rfselect = w_rb;
      end
      S_T4: begin
        bus.o_rfout    = 1'b1;
        bus.o_rfselect = w_rc;
        bus.o_rzin     = 1'b1;
        bus.o_start    = 1'b1;
        bus.o_opselect = {1'b0, w_opcode};
      end
      S_WAIT: begin
        bus.o_opselect = {1'b0, w_opcode};
      end
      S_T5: begin
        bus.o_rzloout = 1'b1;
        if (is_muldiv(w_opcode)) begin
          bus.o_rloin = 1'b1;
        end else begin
          bus.o_rfin     = 1'b1;
          bus.o_rfselect = w_ra;
        end
      end
      S_T6: begin
        bus.o_rzhiout = 1'b1;
        bus.o_rhiin   = 1'b1;
      end
      default: begin
        bus.o_start = 1'b0;
      end
    endcase
  end

  assign bus.o_busy = (r_state != S_IDLE);
  assign bus.o_err  = r_err;

endmodule

// File: tb/tb_alu_op_sequencer.sv
// Scoreboard bench for alu_op_sequencer: stimulus pushes expected per-cycle outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_alu_op_sequencer;

  typedef logic [27:0] vec_t;

  logic clk = 1'b0;
  logic clear;
  int   n_pass = 0;
  int   n_tot = 0;
  int   busy_cnt = 0;
  bit   mon_en = 1'b0;
  vec_t sb[$];

  alu_op_sequencer_if intf ();

  alu_op_sequencer dut (
    .i_clk   (clk),
    .i_clear (clear),
    .bus     (intf)
  );

  always #5 clk = ~clk;

  // Expected output vector per state: 1=T0 2=T1 3=T2 4=T3 5=T4 6=WAIT 7=T5 8=T6, else IDLE.
  // Strobe bit order: pcout incpc marin rzin rzloout pcin read mdrin
  //                   mdrout irin rfout ryin rfin rzhiout rloin rhiin
  function automatic vec_t expv(input int st, input logic [31:0] ir, input bit md);
    logic [15:0] s;
    logic [3:0]  sel;
    logic [5:0]  op;
    logic        stp;
    s = 16'h0; sel = 4'h0; op = 6'h0; stp = 1'b0;
    case (st)
      1: s = 16'b1111_0000_0000_0000;
      2: s = 16'b0000_1111_0000_0000;
      3: s = 16'b0000_0000_1100_0000;
      4: begin s = 16'b0000_0000_0011_0000; sel = ir[22:19]; end
      5: begin s = 16'b0001_0000_0010_0000; sel = ir[18:15]; op = {1'b0, ir[31:27]}; stp = 1'b1; end
      6: op = {1'b0, ir[31:27]};
      7: begin
        if (md) s = 16'b0000_1000_0000_0010;
        else begin s = 16'b0000_1000_0000_1000; sel = ir[26:23]; end
      end
      8: s = 16'b0000_0000_0000_0101;
      default: s = 16'h0;
    endcase
    return {s, sel, op, stp, (st >= 1 && st <= 8) ? 1'b1 : 1'b0};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
  endtask

  // Advance one clock and record what the DUT should show in the new state
  task automatic step(input int st, input bit md);
    @(posedge clk);
    #1;
    if (st != 0) sb.push_back(expv(st, intf.i_irq, md));
  endtask

  task automatic do_instr(input logic [31:0] ir, input int fin_delay, input bit md,
                          input bit run_after, input bit drop_early);
    intf.i_run = 1'b1;
    step(1, md);
    intf.i_irq = ir;
    if (drop_early) intf.i_run = 1'b0;
    step(2, md);
    step(3, md);
    step(4, md);
    step(5, md);
    for (int k = 1; k <= fin_delay; k++) begin
      step(6, md);
      if (k == fin_delay) intf.i_finished = 1'b1;
    end
    step(7, md);
    intf.i_finished = 1'b0;
    if (md) step(8, md);
    intf.i_run = run_after;
  endtask

  task automatic check_cycles(input string name, input int b0, input int expc);
    step(0, 1'b0);
    @(negedge clk);
    #1;
    chk(name, busy_cnt - b0, expc);
  endtask

  // Monitor: every negedge compares outputs to the scoreboard head (empty queue means idle)
  initial begin
    vec_t act;
    vec_t e;
    forever begin
      @(negedge clk);
      if (mon_en) begin
        act = {intf.o_pcout, intf.o_incpc, intf.o_marin, intf.o_rzin,
               intf.o_rzloout, intf.o_pcin, intf.o_read, intf.o_mdrin,
               intf.o_mdrout, intf.o_irin, intf.o_rfout, intf.o_ryin,
               intf.o_rfin, intf.o_rzhiout, intf.o_rloin, intf.o_rhiin,
               intf.o_rfselect, intf.o_opselect, intf.o_start, intf.o_busy};
        if (intf.o_busy) busy_cnt++;
        if (sb.size() != 0) e = sb.pop_front();
        else e = '0;
        chk("outputs", {4'h0, act}, {4'h0, e});
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int b0;
    logic [31:0] ir_add;
    logic [31:0] ir_mul;
    logic [31:0] ir_div;
    ir_add = 32'hC0918000;
    ir_mul = {5'h0E, 4'h5, 4'h6, 4'h7, 15'h0};
    ir_div = {5'h0F, 4'h9, 4'hA, 4'hB, 15'h1234};

    clear = 1'b1;
    intf.i_run = 1'b0;
    intf.i_irq = 32'h0;
    intf.i_finished = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    clear = 1'b0;
    mon_en = 1'b1;
    @(negedge clk);
    #1;
    chk("reset_busy", {31'h0, intf.o_busy}, 32'h0);
    chk("reset_err", {31'h0, intf.o_err}, 32'h0);

    // Basic add: RFSelect 2/3/1, opSelect 18, seven cycles
    b0 = busy_cnt;
    do_instr(ir_add, 1, 1'b0, 1'b0, 1'b0);
    check_cycles("add_cycles", b0, 7);

    // MUL with late finish: HI/LO path, ten cycles
    b0 = busy_cnt;
    do_instr(ir_mul, 3, 1'b1, 1'b0, 1'b0);
    check_cycles("mul_cycles", b0, 10);

    // Back-to-back with run held: no idle gap between instructions
    b0 = busy_cnt;
    do_instr(ir_add, 2, 1'b0, 1'b1, 1'b0);
    do_instr(ir_div, 1, 1'b1, 1'b0, 1'b0);
    check_cycles("b2b_cycles", b0, 16);

    // Lowest legal opcode, run dropped in T0 still completes
    b0 = busy_cnt;
    do_instr({5'h03, 4'hF, 4'hE, 4'hD, 15'h0}, 2, 1'b0, 1'b0, 1'b1);
    check_cycles("op03_drop_cycles", b0, 8);

    // Highest legal opcode
    b0 = busy_cnt;
    do_instr({5'h1A, 4'h4, 4'h8, 4'hC, 15'h7FFF}, 1, 1'b0, 1'b0, 1'b0);
    check_cycles("op1a_cycles", b0, 7);

    // Clear while waiting for the ALU
    intf.i_run = 1'b1;
    step(1, 1'b0);
    intf.i_irq = ir_add;
    step(2, 1'b0); step(3, 1'b0); step(4, 1'b0); step(5, 1'b0);
    step(6, 1'b0); step(6, 1'b0);
    clear = 1'b1;
    intf.i_run = 1'b0;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    #1;
    chk("clear_wait_busy", {31'h0, intf.o_busy}, 32'h0);
    chk("clear_wait_start", {31'h0, intf.o_start}, 32'h0);

    // Illegal opcodes on both sides of the legal range: err, then stay idle with run high
    for (int t = 0; t < 2; t++) begin
      intf.i_run = 1'b1;
      step(1, 1'b0);
      intf.i_irq = (t == 0) ? {5'h1F, 27'h0} : {5'h02, 27'h5555};
      step(2, 1'b0); step(3, 1'b0); step(4, 1'b0);
      repeat (6) step(0, 1'b0);
      @(negedge clk);
      #1;
      chk("illegal_err", {31'h0, intf.o_err}, 32'h1);
      chk("illegal_busy", {31'h0, intf.o_busy}, 32'h0);
      clear = 1'b1;
      intf.i_run = 1'b0;
      @(posedge clk);
      #1;
      clear = 1'b0;
      @(negedge clk);
      #1;
      chk("err_cleared", {31'h0, intf.o_err}, 32'h0);
    end

    // ALU never finishes
    intf.i_run = 1'b1;
    step(1, 1'b0);
    intf.i_irq = ir_add;
    step(2, 1'b0); step(3, 1'b0); step(4, 1'b0); step(5, 1'b0);
    intf.i_run = 1'b0;
`ifdef ALU_TIMEOUT_EN
    repeat (64) step(6, 1'b0);
    step(0, 1'b0);
    @(negedge clk);
    #1;
    chk("timeout_err", {31'h0, intf.o_err}, 32'h1);
    chk("timeout_busy", {31'h0, intf.o_busy}, 32'h0);
`else
    repeat (200) step(6, 1'b0);
    @(negedge clk);
    #1;
    chk("no_timeout_busy", {31'h0, intf.o_busy}, 32'h1);
    chk("no_timeout_err", {31'h0, intf.o_err}, 32'h0);
`endif
    clear = 1'b1;
    @(posedge clk);
    #1;
    clear = 1'b0;
    @(negedge clk);
    #1;
    chk("final_idle", {31'h0, intf.o_busy}, 32'h0);
    chk("sb_drained", sb.size(), 32'h0);

    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
